// File: rtl/rriot_pkg.sv
// Shared definitions for the RRIOT interval timer: prescaler divide
// encodings and the reload value that goes with each one.
package rriot_pkg;

    // Widest prescaler the divide table needs (1023 must fit).
    localparam int PRESC_MAX_W = 10;

    // Divide select as written through A[1:0] on a timer write.
    typedef enum logic [1:0] {
        DIV_1    = 2'b00,
        DIV_8    = 2'b01,
        DIV_64   = 2'b10,
        DIV_1024 = 2'b11
    } div_t;

    // Reload value for the prescaler: divisor minus one, so a reload of
    // zero gives a tick every cycle.
    function automatic logic [PRESC_MAX_W-1:0] divisor_m1(input div_t div);
        logic [PRESC_MAX_W-1:0] value;
        case (div)
            DIV_1:    value = 10'd0;
            DIV_8:    value = 10'd7;
            DIV_64:   value = 10'd63;
            default:  value = 10'd1023;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/rriot_interval_timer_if.sv
// Register access bus and IRQ/PB7 pad controls of the RRIOT timer.
// The core side drives the access signals; the timer answers with read
// data and the pad controls.
interface rriot_interval_timer_if;
    logic       sel;
    logic       we_n;
    logic [3:0] A;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       DO_en;
    logic       irq;
    logic       irq_en;
    logic       flag_o;

    modport master (
        output sel, we_n, A, DI,
        input  DO, DO_en, irq, irq_en, flag_o
    );

    modport slave (
        input  sel, we_n, A, DI,
        output DO, DO_en, irq, irq_en, flag_o
    );
endinterface

// File: rtl/rriot_prescaler.sv
// Prescaler for the RRIOT interval timer. Produces a one-cycle tick every
// `divisor` cycles, or every cycle while bypassed (free-run after underflow).
module rriot_prescaler
    import rriot_pkg::*;
#(
    parameter int PRESC_W = 10
) (
    input  logic phi2,
    input  logic rst,
    input  logic load,
    input  div_t div,
    input  logic bypass,
    output logic tick
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] reload;

    assign reload = PRESC_W'(divisor_m1(div));
    assign tick   = bypass | (presc == '0);

    // Down-count to zero and reload; a load restarts the period, and the
    // counter simply holds while bypassed since every cycle ticks anyway.
    always_ff @(posedge phi2) begin
        if (rst) begin
            presc <= '0;
        end else if (load) begin
            presc <= reload;
        end else if (!bypass) begin
            if (presc == '0) begin
                presc <= reload;
            end else begin
                presc <= presc - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rriot_interval_timer.sv
// RRIOT interval timer and IRQ/PB7 pad controller. Holds the 8-bit count,
// the sticky interrupt flag, the interrupt enable and the free-run state,
// and produces the register read mux.
module rriot_interval_timer
    import rriot_pkg::*;
#(
    parameter int         PRESC_W     = 10,
    parameter logic [7:0] RESET_COUNT = 8'hFF
) (
    input logic                   phi2,
    input logic                   rst,
    rriot_interval_timer_if.slave bus
);

    logic [7:0] count;
    div_t       div;
    logic       flag;
    logic       ie;
    logic       free;

    logic       wr;
    logic       rd_count;
    logic       rd_status;
    logic       tick;
    logic       underflow;
    logic       presc_load;
    div_t       presc_div;
    logic       unused_addr;

    assign wr        = bus.sel & ~bus.we_n;
    assign rd_count  = bus.sel &  bus.we_n & ~bus.A[0];
    assign rd_status = bus.sel &  bus.we_n &  bus.A[0];

    // A write always wins over a simultaneous underflow.
    assign underflow = tick & (count == 8'h00) & ~wr;

    // Restart the period on a write (new rate) or when a count read
    // leaves free-run (programmed rate restored).
    assign presc_load = wr | (rd_count & free);
    assign presc_div  = wr ? div_t'(bus.A[1:0]) : div;

    // A[2] is part of the upstream register decode only.
    assign unused_addr = bus.A[2];

    rriot_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .phi2   (phi2),
        .rst    (rst),
        .load   (presc_load),
        .div    (presc_div),
        .bypass (free),
        .tick   (tick)
    );

    // Timer count: loaded by a write, otherwise decremented on each tick
    // and wrapping 00 -> FF on underflow.
    always_ff @(posedge phi2) begin
        if (rst) begin
            count <= RESET_COUNT;
        end else if (wr) begin
            count <= bus.DI;
        end else if (tick) begin
            count <= count - 8'd1;
        end
    end

    // Divide select is only changed by a write.
    always_ff @(posedge phi2) begin
        if (rst) begin
            div <= DIV_1;
        end else if (wr) begin
            div <= div_t'(bus.A[1:0]);
        end
    end

    // Interrupt flag and free-run: write clears, underflow sets, and a
    // count read clears unless an underflow lands in the same cycle.
    always_ff @(posedge phi2) begin
        if (rst) begin
            flag <= 1'b0;
            free <= 1'b0;
        end else if (wr) begin
            flag <= 1'b0;
            free <= 1'b0;
        end else if (underflow) begin
            flag <= 1'b1;
            free <= 1'b1;
        end else if (rd_count) begin
            flag <= 1'b0;
            free <= 1'b0;
        end
    end

    // Interrupt enable follows A[3] on any timer access.
    always_ff @(posedge phi2) begin
        if (rst) begin
            ie <= 1'b0;
        end else if (bus.sel) begin
            ie <= bus.A[3];
        end
    end

    // Read mux and pad controls; the pad is open-drain so it only ever
    // pulls low when enabled.
    always_comb begin
        bus.DO = 8'h00;
        if (rd_count) begin
            bus.DO = count;
        end else if (rd_status) begin
            bus.DO = {flag, 7'b0};
        end
    end

    assign bus.DO_en  = bus.sel & bus.we_n;
    assign bus.irq    = 1'b0;
    assign bus.irq_en = flag & ie;
    assign bus.flag_o = flag;

endmodule

// File: tb/tb_rriot_interval_timer.sv
// Testbench for rriot_interval_timer: directed accesses push expected read
// results into a queue, and a monitor checks them whenever DO_en is high.
module tb_rriot_interval_timer;
    import rriot_pkg::*;

    logic phi2 = 1'b0;
    logic rst  = 1'b1;

    always #5 phi2 = ~phi2;

    rriot_interval_timer_if bus ();

    rriot_interval_timer #(
        .PRESC_W     (10),
        .RESET_COUNT (8'hFF)
    ) dut (
        .phi2 (phi2),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] do_v;
        logic       flag;
        logic       irq_en;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, req);
        end
    endtask

    // One bus cycle: drive just after a rising edge, sampled at the next one.
    task automatic applyStimulus(input logic s, input logic we, input logic [3:0] a, input logic [7:0] d);
        bus.sel  = s;
        bus.we_n = we;
        bus.A    = a;
        bus.DI   = d;
        @(posedge phi2);
        #1;
        bus.sel  = 1'b0;
        bus.we_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, 4'h0, 8'h00);
    endtask

    task automatic writeTimer(input logic [3:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
    endtask

    task automatic readTimer(input string name, input logic [3:0] a, input logic [7:0] do_v,
                             input logic flag, input logic irq_en);
        exp_t e;
        e.name   = name;
        e.do_v   = do_v;
        e.flag   = flag;
        e.irq_en = irq_en;
        expQ.push_back(e);
        applyStimulus(1'b1, 1'b1, a, 8'h00);
    endtask

    // Monitor: compare every presented read against the scoreboard, and
    // check the bus stays quiet otherwise.
    always @(negedge phi2) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.DO_en) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected read: DO=%02h with nothing expected", bus.DO);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, " DO"}, bus.DO, e.do_v);
                    checkOutput({e.name, " flag"}, {7'b0, bus.flag_o}, {7'b0, e.flag});
                    checkOutput({e.name, " irq_en"}, {7'b0, bus.irq_en}, {7'b0, e.irq_en});
                    checkOutput({e.name, " irq"}, {7'b0, bus.irq}, 8'h00);
                end
            end else begin
                checkOutput("idle DO", bus.DO, 8'h00);
            end
        end
    end

    initial begin
        bus.sel  = 1'b0;
        bus.we_n = 1'b1;
        bus.A    = 4'h0;
        bus.DI   = 8'h00;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge phi2);
        #1;
        checkOutput("reset DO", bus.DO, 8'h00);
        checkOutput("reset DO_en", {7'b0, bus.DO_en}, 8'h00);
        checkOutput("reset irq", {7'b0, bus.irq}, 8'h00);
        checkOutput("reset irq_en", {7'b0, bus.irq_en}, 8'h00);
        checkOutput("reset flag", {7'b0, bus.flag_o}, 8'h00);
        rst = 1'b0;
        readTimer("post-reset count", 4'b0000, 8'hFF, 1'b0, 1'b0);
        readTimer("post-reset count+1", 4'b0000, 8'hFE, 1'b0, 1'b0);

        // Test 1: /1, ie=0, count 5; last read lands on the underflow cycle
        writeTimer(4'b0000, 8'h05);
        idle(1);
        readTimer("t1 c04", 4'b0000, 8'h04, 1'b0, 1'b0);
        readTimer("t1 c03", 4'b0000, 8'h03, 1'b0, 1'b0);
        readTimer("t1 c02", 4'b0000, 8'h02, 1'b0, 1'b0);
        readTimer("t1 c01", 4'b0000, 8'h01, 1'b0, 1'b0);
        readTimer("t1 c00", 4'b0000, 8'h00, 1'b0, 1'b0);
        readTimer("t1 status set", 4'b0001, 8'h80, 1'b1, 1'b0);
        readTimer("t1 count FE", 4'b0000, 8'hFE, 1'b1, 1'b0);
        readTimer("t1 status clr", 4'b0001, 8'h00, 1'b0, 1'b0);

        // Test 2: /8, ie=1, count 2 -> underflow 24 cycles after the write
        writeTimer(4'b1001, 8'h02);
        readTimer("t2 c02", 4'b1000, 8'h02, 1'b0, 1'b0);
        idle(7);
        readTimer("t2 c01", 4'b1000, 8'h01, 1'b0, 1'b0);
        idle(7);
        readTimer("t2 c00", 4'b1000, 8'h00, 1'b0, 1'b0);
        idle(6);
        readTimer("t2 pre-underflow", 4'b1001, 8'h00, 1'b0, 1'b0);
        readTimer("t2 flag irq", 4'b1001, 8'h80, 1'b1, 1'b1);

        // Test 3: free-run at /1, count read clears and restores /8
        readTimer("t3 free FE", 4'b1000, 8'hFE, 1'b1, 1'b1);
        readTimer("t3 cleared", 4'b1001, 8'h00, 1'b0, 1'b0);
        idle(6);
        readTimer("t3 /8 hold FD", 4'b1000, 8'hFD, 1'b0, 1'b0);
        readTimer("t3 /8 step FC", 4'b1000, 8'hFC, 1'b0, 1'b0);

        // Test 4: /1024 with count 0 -> flag exactly 1024 cycles later
        writeTimer(4'b0011, 8'h00);
        idle(1023);
        readTimer("t4 at 1023", 4'b0001, 8'h00, 1'b0, 1'b0);
        readTimer("t4 at 1024", 4'b0001, 8'h80, 1'b1, 1'b0);
        readTimer("t4 sticky", 4'b0001, 8'h80, 1'b1, 1'b0);
        readTimer("t4 count FD", 4'b0000, 8'hFD, 1'b1, 1'b0);
        readTimer("t4 cleared", 4'b0001, 8'h00, 1'b0, 1'b0);

        // Test 5: count read, then write, on the underflow cycle
        writeTimer(4'b0000, 8'h01);
        idle(1);
        readTimer("t5 read@uf", 4'b0000, 8'h00, 1'b0, 1'b0);
        readTimer("t5 set wins", 4'b0001, 8'h80, 1'b1, 1'b0);
        writeTimer(4'b0000, 8'h01);
        idle(1);
        writeTimer(4'b0000, 8'h33);
        readTimer("t5 write wins", 4'b0001, 8'h00, 1'b0, 1'b0);
        readTimer("t5 count DI", 4'b0000, 8'h32, 1'b0, 1'b0);

        // Test 6: reset while the pad is driven
        writeTimer(4'b1000, 8'h00);
        idle(1);
        readTimer("t6 irq on", 4'b1001, 8'h80, 1'b1, 1'b1);
        rst = 1'b1;
        @(posedge phi2);
        #1;
        checkOutput("t6 rst irq_en", {7'b0, bus.irq_en}, 8'h00);
        checkOutput("t6 rst flag", {7'b0, bus.flag_o}, 8'h00);
        checkOutput("t6 rst DO_en", {7'b0, bus.DO_en}, 8'h00);
        rst = 1'b0;
        idle(1);
        readTimer("t6 count FE", 4'b0000, 8'hFE, 1'b0, 1'b0);
        readTimer("t6 /1 FD", 4'b0000, 8'hFD, 1'b0, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && expQ.size() != 0; i++) begin
            idle(1);
        end
        if (expQ.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL scoreboard drain: %0d reads outstanding, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
